// File: rtl/prv_trap_sequencer.sv
// Trap/return sequencer: prioritises exception, interrupt and MRET events, waits for the pipeline
// to drain, strobes the CSR updates, then redirects fetch. Optional macro: PRV_VECTORED_INT_EN.
module prv_trap_sequencer #(
  parameter int CLEAR_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fault_insn,
  input  logic        mal_insn,
  input  logic        illegal_insn,
  input  logic        fault_l,
  input  logic        mal_l,
  input  logic        fault_s,
  input  logic        mal_s,
  input  logic        breakpoint,
  input  logic        env_m,
  input  logic        ret,
  input  logic [31:0] epc,
  input  logic [31:0] badaddr,
  input  logic        timer_int,
  input  logic        soft_int,
  input  logic        ext_int,
  input  logic        mstatus_mie,
  input  logic        pipe_clear,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc_r,
  output logic        intr,
  output logic        insert_pc,
  output logic [31:0] priv_pc,
  output logic        csr_we_trap,
  output logic        csr_we_ret,
  output logic [31:0] mepc_wdata,
  output logic [31:0] mcause_wdata,
  output logic [31:0] mtval_wdata
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT     = 2'd1;
  localparam logic [1:0] S_COMMIT   = 2'd2;
  localparam logic [1:0] S_REDIRECT = 2'd3;

  localparam bit         TIMEOUT_EN   = (CLEAR_TIMEOUT > 0);
  localparam logic [7:0] TIMEOUT_LAST = 8'((CLEAR_TIMEOUT > 0) ? CLEAR_TIMEOUT - 1 : 0);

  logic [1:0]  state_reg;
  logic [7:0]  cnt_reg;
  logic [3:0]  code_reg;
  logic        int_reg;
  logic        ret_reg;
  logic [31:0] epc_reg;
  logic [31:0] tval_reg;

  logic        exc_any;
  logic        int_any;
  logic        event_any;
  logic        ev_int;
  logic        ev_ret;
  logic [3:0]  ev_code;
  logic        ev_tval;
  logic        wait_done;
  logic [31:0] trap_base;
  logic [31:0] trap_pc;
  logic        unused_epc_low;

  assign unused_epc_low = ^epc[1:0];

  assign exc_any   = fault_insn | mal_insn | illegal_insn | fault_l | mal_l |
                     fault_s | mal_s | breakpoint | env_m;
  assign int_any   = mstatus_mie & (ext_int | soft_int | timer_int);
  assign event_any = exc_any | int_any | ret;

  // Exceptions outrank interrupts, which outrank MRET; a dropped MRET simply never commits.
  always_comb begin
    ev_code = 4'd0;
    ev_int  = 1'b0;
    ev_ret  = 1'b0;
    if (fault_insn)        ev_code = 4'd1;
    else if (illegal_insn) ev_code = 4'd2;
    else if (mal_insn)     ev_code = 4'd0;
    else if (env_m)        ev_code = 4'd11;
    else if (breakpoint)   ev_code = 4'd3;
    else if (mal_s)        ev_code = 4'd6;
    else if (mal_l)        ev_code = 4'd4;
    else if (fault_s)      ev_code = 4'd7;
    else if (fault_l)      ev_code = 4'd5;
    else if (int_any) begin
      ev_int = 1'b1;
      if (ext_int)       ev_code = 4'd11;
      else if (soft_int) ev_code = 4'd3;
      else               ev_code = 4'd7;
    end else if (ret) begin
      ev_ret = 1'b1;
    end
  end

  // Only address-bearing exceptions carry badaddr into mtval.
  always_comb begin
    ev_tval = 1'b0;
    if (exc_any) begin
      case (ev_code)
        4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7: ev_tval = 1'b1;
        default:                             ev_tval = 1'b0;
      endcase
    end
  end

  assign wait_done = pipe_clear | (TIMEOUT_EN && (cnt_reg == TIMEOUT_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 8'd0;
      code_reg  <= 4'd0;
      int_reg   <= 1'b0;
      ret_reg   <= 1'b0;
      epc_reg   <= 32'd0;
      tval_reg  <= 32'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (event_any) begin
            state_reg <= S_WAIT;
            code_reg  <= ev_code;
            int_reg   <= ev_int;
            ret_reg   <= ev_ret;
            epc_reg   <= {epc[31:2], 2'b00};
            tval_reg  <= ev_tval ? badaddr : 32'd0;
          end
        end
        S_WAIT: begin
          if (wait_done) begin
            state_reg <= S_COMMIT;
            cnt_reg   <= 8'd0;
          end else if (cnt_reg != 8'hFF) begin
            cnt_reg   <= cnt_reg + 8'd1;
          end
        end
        S_COMMIT:   state_reg <= S_REDIRECT;
        default:    state_reg <= S_IDLE;
      endcase
    end
  end

  assign trap_base = {mtvec[31:2], 2'b00};

`ifdef PRV_VECTORED_INT_EN
  assign trap_pc = (int_reg && (mtvec[1:0] == 2'b01)) ? trap_base + {26'd0, code_reg, 2'b00}
                                                     : trap_base;
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec[1:0];
  assign trap_pc = trap_base;
`endif

  assign intr         = (state_reg != S_IDLE);
  assign csr_we_trap  = (state_reg == S_COMMIT) && !ret_reg;
  assign csr_we_ret   = (state_reg == S_COMMIT) && ret_reg;
  assign insert_pc    = (state_reg == S_REDIRECT);
  // mepc_r is read live in REDIRECT so a return sees the value written by the preceding commit.
  assign priv_pc      = (state_reg == S_REDIRECT) ? (ret_reg ? mepc_r : trap_pc) : 32'd0;
  assign mepc_wdata   = epc_reg;
  assign mcause_wdata = {int_reg, 27'd0, code_reg};
  assign mtval_wdata  = tval_reg;

endmodule

// File: tb/tb_prv_trap_sequencer.sv
// Bench for prv_trap_sequencer: two instances (CLEAR_TIMEOUT 16 and 4) share stimulus and are
// checked cycle by cycle against an event-level reference model.
module tb_prv_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s, breakpoint, env_m;
  logic        ret;
  logic [31:0] epc, badaddr;
  logic        timer_int, soft_int, ext_int, mstatus_mie, pipe_clear;
  logic [31:0] mtvec, mepc_r;

  logic [1:0]  intr_w, insert_w, we_trap_w, we_ret_w;
  logic [31:0] pc_w    [2];
  logic [31:0] mepc_w  [2];
  logic [31:0] cause_w [2];
  logic [31:0] tval_w  [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prv_trap_sequencer dut16 (
    .clk(clk), .rst(rst),
    .fault_insn(fault_insn), .mal_insn(mal_insn), .illegal_insn(illegal_insn),
    .fault_l(fault_l), .mal_l(mal_l), .fault_s(fault_s), .mal_s(mal_s),
    .breakpoint(breakpoint), .env_m(env_m), .ret(ret), .epc(epc), .badaddr(badaddr),
    .timer_int(timer_int), .soft_int(soft_int), .ext_int(ext_int),
    .mstatus_mie(mstatus_mie), .pipe_clear(pipe_clear), .mtvec(mtvec), .mepc_r(mepc_r),
    .intr(intr_w[0]), .insert_pc(insert_w[0]), .priv_pc(pc_w[0]),
    .csr_we_trap(we_trap_w[0]), .csr_we_ret(we_ret_w[0]),
    .mepc_wdata(mepc_w[0]), .mcause_wdata(cause_w[0]), .mtval_wdata(tval_w[0])
  );

  prv_trap_sequencer #(.CLEAR_TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst),
    .fault_insn(fault_insn), .mal_insn(mal_insn), .illegal_insn(illegal_insn),
    .fault_l(fault_l), .mal_l(mal_l), .fault_s(fault_s), .mal_s(mal_s),
    .breakpoint(breakpoint), .env_m(env_m), .ret(ret), .epc(epc), .badaddr(badaddr),
    .timer_int(timer_int), .soft_int(soft_int), .ext_int(ext_int),
    .mstatus_mie(mstatus_mie), .pipe_clear(pipe_clear), .mtvec(mtvec), .mepc_r(mepc_r),
    .intr(intr_w[1]), .insert_pc(insert_w[1]), .priv_pc(pc_w[1]),
    .csr_we_trap(we_trap_w[1]), .csr_we_ret(we_ret_w[1]),
    .mepc_wdata(mepc_w[1]), .mcause_wdata(cause_w[1]), .mtval_wdata(tval_w[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // ex bit order: fault_insn, illegal, mal_insn, env_m, breakpoint, mal_s, mal_l, fault_s, fault_l
  // irq bit order: ext, soft, timer
  task automatic set_flags(input logic [8:0] ex, input logic [2:0] irq, input logic rt);
    fault_insn = ex[0]; illegal_insn = ex[1]; mal_insn = ex[2]; env_m = ex[3];
    breakpoint = ex[4]; mal_s = ex[5]; mal_l = ex[6]; fault_s = ex[7]; fault_l = ex[8];
    ext_int = irq[0]; soft_int = irq[1]; timer_int = irq[2];
    ret = rt;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s intr[%0d]", tag, k), 32'(intr_w[k]), 32'd0);
      chk($sformatf("%s insert_pc[%0d]", tag, k), 32'(insert_w[k]), 32'd0);
      chk($sformatf("%s we_trap[%0d]", tag, k), 32'(we_trap_w[k]), 32'd0);
      chk($sformatf("%s we_ret[%0d]", tag, k), 32'(we_ret_w[k]), 32'd0);
      chk($sformatf("%s priv_pc[%0d]", tag, k), pc_w[k], 32'd0);
    end
  endtask

  // 0 idle, 1 waiting, 2 commit, 3 redirect, given c cycles after the trigger and j extra wait cycles
  function automatic int phase(input int c, input int j);
    if (c >= 1 && c <= j + 1) return 1;
    if (c == j + 2) return 2;
    if (c == j + 3) return 3;
    return 0;
  endfunction

  task automatic do_seq(input string name, input logic [8:0] ex, input logic [2:0] irq,
                        input logic mie, input logic rt, input logic [31:0] e_pc,
                        input logic [31:0] b_addr, input logic [31:0] tvec,
                        input logic [31:0] mr, input int d);
    int          exc_code [9] = '{1, 2, 0, 11, 3, 6, 4, 7, 5};
    int          to_v [2] = '{16, 4};
    int          kind;
    int          j [2];
    int          jmin, jmax, p;
    logic [31:0] ecause, etval, epc_exp, pc_exp;
    logic        is_int;
    int          code;
    set_flags(ex, irq, rt);
    mstatus_mie = mie; epc = e_pc; badaddr = b_addr; mtvec = tvec; mepc_r = mr;
    kind = 0; code = 0; is_int = 1'b0; etval = 32'd0;
    if (ex != 9'd0) begin
      for (int i = 8; i >= 0; i--) if (ex[i]) code = exc_code[i];
      kind = 1;
      if (code == 0 || code == 1 || (code >= 4 && code <= 7)) etval = b_addr;
    end else if (mie && irq != 3'd0) begin
      kind = 1; is_int = 1'b1;
      code = irq[0] ? 11 : (irq[1] ? 3 : 7);
    end else if (rt) begin
      kind = 2;
    end
    ecause  = {is_int, 31'(code)};
    epc_exp = {e_pc[31:2], 2'b00};
    pc_exp  = {tvec[31:2], 2'b00};
`ifdef PRV_VECTORED_INT_EN
    if (is_int && tvec[1:0] == 2'b01) pc_exp = pc_exp + 32'(4 * code);
`endif
    if (kind == 2) pc_exp = mr;
    for (int k = 0; k < 2; k++) j[k] = (kind == 0) ? -3 : ((d < to_v[k] - 1) ? d : to_v[k] - 1);
    jmin = (j[0] < j[1]) ? j[0] : j[1];
    jmax = (j[0] > j[1]) ? j[0] : j[1];
    $display("seq %s kind=%0d cause=%h tval=%h pc=%h wait16=%0d wait4=%0d",
             name, kind, ecause, etval, pc_exp, j[0] + 1, j[1] + 1);
    for (int c = 1; c <= jmax + 4; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        p = phase(c, j[k]);
        chk($sformatf("%s c%0d intr[%0d]", name, c, k), 32'(intr_w[k]), 32'(p != 0));
        chk($sformatf("%s c%0d we_trap[%0d]", name, c, k), 32'(we_trap_w[k]),
            32'(p == 2 && kind == 1));
        chk($sformatf("%s c%0d we_ret[%0d]", name, c, k), 32'(we_ret_w[k]),
            32'(p == 2 && kind == 2));
        chk($sformatf("%s c%0d insert_pc[%0d]", name, c, k), 32'(insert_w[k]), 32'(p == 3));
        if (p == 3) chk($sformatf("%s priv_pc[%0d]", name, k), pc_w[k], pc_exp);
        if (p == 2 && kind == 1) begin
          chk($sformatf("%s mepc[%0d]", name, k), mepc_w[k], epc_exp);
          chk($sformatf("%s mcause[%0d]", name, k), cause_w[k], ecause);
          chk($sformatf("%s mtval[%0d]", name, k), tval_w[k], etval);
        end
      end
      pipe_clear = (c - 1 >= d);
      if (c <= jmin + 3) begin
        set_flags(9'($urandom), 3'($urandom), 1'($urandom));
        mstatus_mie = 1'($urandom); epc = $urandom; badaddr = $urandom;
      end else begin
        set_flags(9'd0, 3'd0, 1'b0);
      end
    end
    set_flags(9'd0, 3'd0, 1'b0);
  endtask

  initial begin
    logic [8:0] rex;
    logic [2:0] rirq;
    rst = 1'b1;
    set_flags(9'd0, 3'd0, 1'b0);
    epc = 32'd0; badaddr = 32'd0; mstatus_mie = 1'b0; pipe_clear = 1'b0;
    mtvec = 32'd0; mepc_r = 32'd0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset mepc[%0d]", k), mepc_w[k], 32'd0);
      chk($sformatf("reset mcause[%0d]", k), cause_w[k], 32'd0);
      chk($sformatf("reset mtval[%0d]", k), tval_w[k], 32'd0);
    end
    rst = 1'b0;
    pipe_clear = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");

    do_seq("t1_illegal", 9'h002, 3'd0, 1'b0, 1'b0, 32'h100, 32'h55, 32'h8000, 32'h0, 0);
    do_seq("t2_mal_l", 9'h040, 3'b001, 1'b1, 1'b0, 32'h204, 32'h203, 32'h8000, 32'h0, 0);
    do_seq("t2_ext", 9'h000, 3'b001, 1'b1, 1'b0, 32'h208, 32'h0, 32'h8000, 32'h0, 0);
    do_seq("t3_ret", 9'h000, 3'b000, 1'b0, 1'b1, 32'h300, 32'h0, 32'h8000, 32'h440, 5);
    do_seq("t4_env", 9'h008, 3'b000, 1'b0, 1'b0, 32'h310, 32'h77, 32'h8000, 32'h0, 1000);
    do_seq("t5_timer", 9'h000, 3'b100, 1'b1, 1'b0, 32'h320, 32'h0, 32'h8001, 32'h0, 0);
    do_seq("ret_vs_exc", 9'h020, 3'b000, 1'b0, 1'b1, 32'h333, 32'hABC, 32'h9002, 32'h0, 2);
    do_seq("masked_int", 9'h000, 3'b111, 1'b0, 1'b0, 32'h340, 32'h0, 32'h8000, 32'h0, 0);

    // Reset asserted in the middle of the commit cycle must kill the strobes at once.
    set_flags(9'h002, 3'd0, 1'b0);
    pipe_clear = 1'b1; epc = 32'h500; mtvec = 32'h8000;
    @(negedge clk);
    set_flags(9'd0, 3'd0, 1'b0);
    @(negedge clk);
    chk("t6 commit we_trap[0]", 32'(we_trap_w[0]), 32'd1);
    chk("t6 commit we_trap[1]", 32'(we_trap_w[1]), 32'd1);
    rst = 1'b1;
    #1;
    chk_all_zero("t6_in_reset");
    @(negedge clk);
    chk_all_zero("t6_held");
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("t6_released");
    do_seq("t6_after", 9'h100, 3'd0, 1'b0, 1'b0, 32'h604, 32'h6FF, 32'h8000, 32'h0, 1);

    for (int n = 0; n < 40; n++) begin
      rex  = 9'd0;
      rirq = 3'd0;
      for (int b = 0; b < 9; b++) rex[b] = ($urandom_range(0, 11) == 0);
      for (int b = 0; b < 3; b++) rirq[b] = ($urandom_range(0, 3) == 0);
      do_seq($sformatf("rnd%0d", n), rex, rirq, 1'($urandom), ($urandom_range(0, 2) == 0),
             $urandom, $urandom, $urandom, $urandom,
             ($urandom_range(0, 7) == 0) ? 40 : $urandom_range(0, 6));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
